// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: ALU opcode encoding, instruction field constants
// and the decoded control bundle passed from decode to execute.
package riscv_pkg;

   typedef enum logic [3:0] {
      ALU_ADD      = 4'd0,
      ALU_AND      = 4'd1,
      ALU_SLL      = 4'd2,
      ALU_SRL      = 4'd3,
      ALU_OR       = 4'd4,
      ALU_XOR      = 4'd5,
      ALU_OUT_ONE  = 4'd6,
      ALU_OUT_ZERO = 4'd7,
      ALU_SRA      = 4'd8,
      ALU_LUI      = 4'd9,
      ALU_SUB      = 4'd10,
      ALU_AUIPC    = 4'd11
   } alu_op_t;

   typedef enum logic [2:0] {
      IMM_NONE,
      IMM_I,
      IMM_S,
      IMM_B,
      IMM_J,
      IMM_U_RAW,
      IMM_U
   } imm_fmt_t;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   typedef struct packed {
      alu_op_t    alu_op;
      logic       op_a_sel;
      logic       op_b_sel;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [4:0] rd;
      logic       reg_we;
      logic       mem_rd;
      logic       mem_wr;
      logic [2:0] funct3;
      logic       branch;
      logic       jump;
      logic [1:0] slt;
      logic       illegal;
   } ctrl_t;

   // Shared by OP and OP-IMM; alt selects SUB/SRA. Compares run as SUB.
   function automatic alu_op_t f3_alu_op(input logic [2:0] f3, input logic alt);
      f3_alu_op = ALU_ADD;
      case (f3)
         F3_ADD:  f3_alu_op = alt ? ALU_SUB : ALU_ADD;
         F3_SLL:  f3_alu_op = ALU_SLL;
         F3_SLT:  f3_alu_op = ALU_SUB;
         F3_SLTU: f3_alu_op = ALU_SUB;
         F3_XOR:  f3_alu_op = ALU_XOR;
         F3_SR:   f3_alu_op = alt ? ALU_SRA : ALU_SRL;
         F3_OR:   f3_alu_op = ALU_OR;
         F3_AND:  f3_alu_op = ALU_AND;
      endcase
   endfunction

endpackage

// File: rtl/riscv_imm_gen.sv
// Immediate extraction for every RV32I format; purely combinational so the
// fetch-side branch predictor can share it.
module riscv_imm_gen
   import riscv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:7]     instr,
   input  imm_fmt_t        fmt,
   output logic [XLEN-1:0] imm
);

   logic [31:0] imm32;

   always_comb begin
      // NOTE: default assigned before the case so no path leaves imm32 unassigned (no latch).
      imm32 = '0;
      case (fmt)
         IMM_I:     imm32 = {{20{instr[31]}}, instr[31:20]};
         IMM_S:     imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         IMM_B:     imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         IMM_J:     imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         IMM_U_RAW: imm32 = {12'b0, instr[31:12]};
         IMM_U:     imm32 = {instr[31:12], 12'b0};
         default:   imm32 = '0;
      endcase
   end

   assign imm = XLEN'(signed'(imm32));

endmodule

// File: rtl/riscv_decode.sv
// RV32I decode stage: one registered bundle with valid/ready on both sides
// and a flush that kills both the held and the incoming instruction.
module riscv_decode
   import riscv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid_i,
   output logic            in_ready_o,
   input  logic [31:0]     instr_i,
   input  logic [XLEN-1:0] pc_i,
   input  logic            flush_i,
   output logic            out_valid_o,
   input  logic            out_ready_i,
   output logic [3:0]      alu_op_o,
   output logic            op_a_sel_o,
   output logic            op_b_sel_o,
   output logic [XLEN-1:0] imm_o,
   output logic [4:0]      rs1_o,
   output logic [4:0]      rs2_o,
   output logic [4:0]      rd_o,
   output logic            reg_we_o,
   output logic            mem_rd_o,
   output logic            mem_wr_o,
   output logic [2:0]      funct3_o,
   output logic            branch_o,
   output logic            jump_o,
   output logic [1:0]      slt_o,
   output logic            illegal_o,
   output logic [XLEN-1:0] pc_o
);

   logic [6:0]      opcode;
   logic [2:0]      funct3;
   logic [6:0]      funct7;
   ctrl_t           dec;
   ctrl_t           ctrl_q;
   imm_fmt_t        fmt;
   logic            illegal;
   logic [XLEN-1:0] imm_d;
   logic [XLEN-1:0] imm_q;
   logic [XLEN-1:0] pc_q;
   logic            valid_q;
   logic            accept;

   assign opcode = instr_i[6:0];
   assign funct3 = instr_i[14:12];
   assign funct7 = instr_i[31:25];

   riscv_imm_gen #(.XLEN(XLEN)) u_imm_gen (
      .instr (instr_i[31:7]),
      .fmt   (fmt),
      .imm   (imm_d)
   );

   always_comb begin
      dec        = '0;
      dec.alu_op = ALU_ADD;
      dec.rs1    = instr_i[19:15];
      dec.rs2    = instr_i[24:20];
      dec.rd     = instr_i[11:7];
      dec.funct3 = funct3;
      fmt        = IMM_NONE;
      illegal    = 1'b0;
      case (opcode)
         OPC_OP: begin
            dec.reg_we = 1'b1;
            dec.alu_op = f3_alu_op(funct3, funct7 == F7_ALT);
            dec.slt    = {funct3 == F3_SLTU, funct3 == F3_SLT || funct3 == F3_SLTU};
            illegal    = !(funct7 == F7_BASE ||
                           (funct7 == F7_ALT && (funct3 == F3_ADD || funct3 == F3_SR)));
         end
         OPC_OPIMM: begin
            fmt          = IMM_I;
            dec.op_b_sel = 1'b1;
            dec.reg_we   = 1'b1;
            // instr[30] is an immediate bit except on shifts, where it picks SRAI.
            dec.alu_op   = f3_alu_op(funct3, funct3 == F3_SR && funct7 == F7_ALT);
            dec.slt      = {funct3 == F3_SLTU, funct3 == F3_SLT || funct3 == F3_SLTU};
            if (funct3 == F3_SLL)
               illegal = funct7 != F7_BASE;
            else if (funct3 == F3_SR)
               illegal = !(funct7 == F7_BASE || funct7 == F7_ALT);
         end
         OPC_LOAD: begin
            fmt          = IMM_I;
            dec.op_b_sel = 1'b1;
            dec.reg_we   = 1'b1;
            dec.mem_rd   = 1'b1;
            illegal      = funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111;
         end
         OPC_STORE: begin
            fmt          = IMM_S;
            dec.op_b_sel = 1'b1;
            dec.mem_wr   = 1'b1;
            illegal      = funct3 > 3'b010;
         end
         OPC_BRANCH: begin
            fmt          = IMM_B;
            dec.op_a_sel = 1'b1;
            dec.op_b_sel = 1'b1;
            dec.branch   = 1'b1;
            illegal      = funct3 == 3'b010 || funct3 == 3'b011;
         end
         OPC_JAL: begin
            fmt          = IMM_J;
            dec.op_a_sel = 1'b1;
            dec.op_b_sel = 1'b1;
            dec.jump     = 1'b1;
            dec.reg_we   = 1'b1;
         end
         OPC_JALR: begin
            fmt          = IMM_I;
            dec.op_b_sel = 1'b1;
            dec.jump     = 1'b1;
            dec.reg_we   = 1'b1;
            illegal      = funct3 != 3'b000;
         end
         OPC_LUI: begin
            fmt          = IMM_U_RAW;
            dec.alu_op   = ALU_LUI;
            dec.op_b_sel = 1'b1;
            dec.reg_we   = 1'b1;
         end
         OPC_AUIPC: begin
            fmt          = IMM_U;
            dec.op_a_sel = 1'b1;
            dec.op_b_sel = 1'b1;
            dec.reg_we   = 1'b1;
         end
         default: illegal = 1'b1;
      endcase
      // An illegal instruction still flows down the pipe, but with no side effects.
      if (illegal) begin
         dec.alu_op   = ALU_OUT_ZERO;
         dec.op_a_sel = 1'b0;
         dec.op_b_sel = 1'b0;
         dec.reg_we   = 1'b0;
         dec.mem_rd   = 1'b0;
         dec.mem_wr   = 1'b0;
         dec.branch   = 1'b0;
         dec.jump     = 1'b0;
         dec.slt      = 2'b00;
      end
      dec.illegal = illegal;
      if (dec.rd == 5'd0)
         dec.reg_we = 1'b0;
   end

   assign in_ready_o = !flush_i && (!valid_q || out_ready_i);
   assign accept     = in_valid_i && in_ready_o;

   // NOTE: non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         ctrl_q  <= '0;
         imm_q   <= '0;
         pc_q    <= '0;
      end else if (flush_i) begin
         valid_q <= 1'b0;
      end else if (accept) begin
         valid_q <= 1'b1;
         ctrl_q  <= dec;
         imm_q   <= imm_d;
         pc_q    <= pc_i;
      end else if (out_ready_i) begin
         valid_q <= 1'b0;
      end
   end

   assign out_valid_o = valid_q;
   assign alu_op_o    = ctrl_q.alu_op;
   assign op_a_sel_o  = ctrl_q.op_a_sel;
   assign op_b_sel_o  = ctrl_q.op_b_sel;
   assign imm_o       = imm_q;
   assign rs1_o       = ctrl_q.rs1;
   assign rs2_o       = ctrl_q.rs2;
   assign rd_o        = ctrl_q.rd;
   assign reg_we_o    = ctrl_q.reg_we;
   assign mem_rd_o    = ctrl_q.mem_rd;
   assign mem_wr_o    = ctrl_q.mem_wr;
   assign funct3_o    = ctrl_q.funct3;
   assign branch_o    = ctrl_q.branch;
   assign jump_o      = ctrl_q.jump;
   assign slt_o       = ctrl_q.slt;
   assign illegal_o   = ctrl_q.illegal;
   assign pc_o        = pc_q;

endmodule

// File: tb/tb_riscv_decode.sv
// Scoreboard bench for riscv_decode: expected bundles are queued on accept
// and compared whenever the stage presents a valid bundle.
module tb_riscv_decode;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [3:0]  alu_op;
      logic        op_a;
      logic        op_b;
      logic [31:0] imm;
      logic        we;
      logic        mrd;
      logic        mwr;
      logic        br;
      logic        jp;
      logic [1:0]  slt;
      logic        ill;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready, flush, out_valid, out_ready;
   logic [31:0] instr, pc, imm, pc_out;
   logic [3:0]  alu_op;
   logic        op_a_sel, op_b_sel, reg_we, mem_rd, mem_wr, branch, jump, illegal;
   logic [4:0]  rs1, rs2, rd;
   logic [2:0]  funct3;
   logic [1:0]  slt;

   int   n_cmp = 0;
   int   n_err = 0;
   exp_t q[$];
   exp_t cur_exp;
   logic lat_pend = 1'b0;
   logic rand_ready = 1'b0;
   exp_t tbl[8];

   always #5 clk = ~clk;

   riscv_decode #(.XLEN(32)) dut (
      .clk(clk), .rst(rst),
      .in_valid_i(in_valid), .in_ready_o(in_ready),
      .instr_i(instr), .pc_i(pc), .flush_i(flush),
      .out_valid_o(out_valid), .out_ready_i(out_ready),
      .alu_op_o(alu_op), .op_a_sel_o(op_a_sel), .op_b_sel_o(op_b_sel),
      .imm_o(imm), .rs1_o(rs1), .rs2_o(rs2), .rd_o(rd),
      .reg_we_o(reg_we), .mem_rd_o(mem_rd), .mem_wr_o(mem_wr),
      .funct3_o(funct3), .branch_o(branch), .jump_o(jump),
      .slt_o(slt), .illegal_o(illegal), .pc_o(pc_out)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   function automatic exp_t mk(input logic [31:0] i, input logic [31:0] p, input logic [3:0] alu,
                               input logic a, input logic b, input logic [31:0] im,
                               input logic we, input logic mrd, input logic mwr,
                               input logic br, input logic jp, input logic [1:0] s, input logic il);
      exp_t e;
      e.instr = i; e.pc = p; e.alu_op = alu; e.op_a = a; e.op_b = b; e.imm = im;
      e.we = we; e.mrd = mrd; e.mwr = mwr; e.br = br; e.jp = jp; e.slt = s; e.ill = il;
      return e;
   endfunction

   task automatic cmp_bundle(input exp_t e);
      string p;
      p = $sformatf("%08h.", e.instr);
      check({p, "alu_op"},   alu_op,   e.alu_op);
      check({p, "op_a_sel"}, op_a_sel, e.op_a);
      check({p, "op_b_sel"}, op_b_sel, e.op_b);
      check({p, "imm"},      imm,      e.imm);
      check({p, "rs1"},      rs1,      e.instr[19:15]);
      check({p, "rs2"},      rs2,      e.instr[24:20]);
      check({p, "rd"},       rd,       e.instr[11:7]);
      check({p, "reg_we"},   reg_we,   e.we);
      check({p, "mem_rd"},   mem_rd,   e.mrd);
      check({p, "mem_wr"},   mem_wr,   e.mwr);
      check({p, "funct3"},   funct3,   e.instr[14:12]);
      check({p, "branch"},   branch,   e.br);
      check({p, "jump"},     jump,     e.jp);
      check({p, "slt"},      slt,      e.slt);
      check({p, "illegal"},  illegal,  e.ill);
      check({p, "pc"},       pc_out,   e.pc);
   endtask

   // Monitor: outputs are registered, so the falling edge sees settled values.
   always @(negedge clk) begin
      if (lat_pend) begin
         check("latency_valid", out_valid, 1);
         lat_pend = 1'b0;
      end
      check("in_ready", in_ready, !flush && (!out_valid || out_ready));
      if (out_valid) begin
         if (flush) begin
            if (q.size() > 0) void'(q.pop_front());
         end else if (q.size() == 0) begin
            check("unexpected_bundle", out_valid, 0);
         end else begin
            cmp_bundle(q[0]);
            if (out_ready) void'(q.pop_front());
         end
      end
      if (in_valid && in_ready && !rst) begin
         q.push_back(cur_exp);
         lat_pend = 1'b1;
      end
   end

   always begin
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
   end

   task automatic drive(input exp_t e);
      int   n;
      logic acc;
      n = 0;
      in_valid = 1'b1; instr = e.instr; pc = e.pc; cur_exp = e;
      do begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
         n++;
      end while (!acc && n < 50);
      if (!acc) check("accept_timeout", 0, 1);
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e_addi, e_sub, e_lui, e_auipc, e_slt, e_sltiu, e_nop, e_ill1, e_ill2, e_ill3;
      exp_t e_lw, e_sw, e_beq, e_jal, e_jalr, e_srai, e_xor, e_sra;
      e_addi  = mk(32'h00A00093, 32'h0, 0,  0, 1, 32'd10,       1, 0, 0, 0, 0, 2'b00, 0);
      e_sub   = mk(32'h40208133, 32'h4, 10, 0, 0, 32'd0,        1, 0, 0, 0, 0, 2'b00, 0);
      e_lui   = mk(32'h123450B7, 32'h8, 9,  0, 1, 32'h00012345, 1, 0, 0, 0, 0, 2'b00, 0);
      e_auipc = mk(32'h00001097, 32'h100, 0, 1, 1, 32'h1000,    1, 0, 0, 0, 0, 2'b00, 0);
      e_slt   = mk(32'h0020A1B3, 32'h104, 10, 0, 0, 32'd0,      1, 0, 0, 0, 0, 2'b01, 0);
      e_sltiu = mk(32'h0050B193, 32'h108, 10, 0, 1, 32'd5,      1, 0, 0, 0, 0, 2'b11, 0);
      e_nop   = mk(32'h00000013, 32'h10C, 0,  0, 1, 32'd0,      0, 0, 0, 0, 0, 2'b00, 0);
      e_ill1  = mk(32'hFFFFFFFF, 32'h110, 7,  0, 0, 32'd0,      0, 0, 0, 0, 0, 2'b00, 1);
      e_ill2  = mk(32'h0000007F, 32'h114, 7,  0, 0, 32'd0,      0, 0, 0, 0, 0, 2'b00, 1);
      e_ill3  = mk(32'h02009093, 32'h118, 7,  0, 0, 32'h20,     0, 0, 0, 0, 0, 2'b00, 1);
      e_lw    = mk(32'hFFC12283, 32'h200, 0,  0, 1, 32'hFFFFFFFC, 1, 1, 0, 0, 0, 2'b00, 0);
      e_sw    = mk(32'h00612423, 32'h204, 0,  0, 1, 32'd8,      0, 0, 1, 0, 0, 2'b00, 0);
      e_beq   = mk(32'hFE208CE3, 32'h208, 0,  1, 1, 32'hFFFFFFF8, 0, 0, 0, 1, 0, 2'b00, 0);
      e_jal   = mk(32'h001000EF, 32'h20C, 0,  1, 1, 32'h800,    1, 0, 0, 0, 1, 2'b00, 0);
      e_jalr  = mk(32'h010280E7, 32'h210, 0,  0, 1, 32'd16,     1, 0, 0, 0, 1, 2'b00, 0);
      e_srai  = mk(32'h40325213, 32'h214, 8,  0, 1, 32'h403,    1, 0, 0, 0, 0, 2'b00, 0);
      e_xor   = mk(32'h0020C3B3, 32'h218, 5,  0, 0, 32'd0,      1, 0, 0, 0, 0, 2'b00, 0);
      e_sra   = mk(32'h403150B3, 32'h21C, 8,  0, 0, 32'd0,      1, 0, 0, 0, 0, 2'b00, 0);
      tbl = '{e_lw, e_sw, e_beq, e_jal, e_jalr, e_srai, e_xor, e_sra};

      rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
      instr = '0; pc = '0; cur_exp = e_nop;
      #12;
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_alu_op", alu_op, 0);
      check("rst_imm", imm, 0);
      check("rst_pc", pc_out, 0);
      check("rst_reg_we", reg_we, 0);
      @(posedge clk); #1; rst = 1'b0;
      idle(1);

      drive(e_addi);
      idle(1);

      // Stall a SUB for three cycles, then release.
      out_ready = 1'b0;
      drive(e_sub);
      repeat (3) begin
         @(negedge clk);
         check("stall_in_ready", in_ready, 0);
         check("stall_alu_op", alu_op, 10);
      end
      @(posedge clk); #1; out_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("sub_done_valid", out_valid, 0);
      @(posedge clk); #1;

      drive(e_lui); drive(e_auipc); drive(e_slt); drive(e_sltiu);
      drive(e_nop); drive(e_ill1); drive(e_ill2); drive(e_ill3);
      idle(2);

      drive(e_lw); drive(e_sw); drive(e_beq); drive(e_jal);
      idle(2);

      // Flush in the third cycle: held SW dropped, BEQ never accepted.
      drive(e_lw); drive(e_sw);
      in_valid = 1'b1; instr = e_beq.instr; pc = e_beq.pc; cur_exp = e_beq; flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      drive(e_jal);
      idle(2);

      rand_ready = 1'b1;
      for (int r = 0; r < 3; r++)
         for (int k = 0; k < 8; k++) drive(tbl[k]);
      rand_ready = 1'b0; out_ready = 1'b1;
      idle(4);
      check("queue_drained", q.size(), 0);

      // Asynchronous reset while a bundle is stalled.
      out_ready = 1'b0;
      drive(e_xor);
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      check("async_rst_valid", out_valid, 0);
      check("async_rst_alu_op", alu_op, 0);
      check("async_rst_imm", imm, 0);
      check("async_rst_rd", rd, 0);
      check("async_rst_pc", pc_out, 0);
      q.delete();
      lat_pend = 1'b0;
      @(posedge clk); #1; rst = 1'b0; out_ready = 1'b1;
      drive(e_srai);
      idle(3);
      check("final_queue_empty", q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/riscv_decode.md
Name: riscv_decode

Overview:
- Decode stage of the RV32I core: accepts a fetched instruction + PC, produces the ALU opcode, operand selects, immediate and control bits consumed by the ALU/execute stage.
- One registered pipeline stage with valid/ready handshake on both sides, plus a flush input for taken branches and jumps.
- alu_op_o uses the same 4-bit encoding the ALU decodes.

Parameters:
- XLEN, 32, datapath width of instr/pc/imm.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid_i  in  1  fetch presents instr_i/pc_i.
- in_ready_o  out  1  decode can accept this cycle.
- instr_i  in  32  raw instruction.
- pc_i  in  32  instruction address.
- flush_i  in  1  kill held and incoming instruction.
- out_valid_o  out  1  decoded bundle valid.
- out_ready_i  in  1  execute accepts bundle.
- alu_op_o  out  4  ADD=0 AND=1 SLL=2 SRL=3 OR=4 XOR=5 OUT_ONE=6 OUT_ZERO=7 SRA=8 LUI=9 SUB=10 AUIPC=11.
- op_a_sel_o  out  1  0=rs1, 1=pc.
- op_b_sel_o  out  1  0=rs2, 1=imm.
- imm_o  out  32  decoded immediate.
- rs1_o, rs2_o, rd_o  out  5 each  register indices.
- reg_we_o  out  1  writeback enable; forced 0 when rd=0.
- mem_rd_o, mem_wr_o  out  1 each  load/store.
- funct3_o  out  3  size/sign for loads/stores, condition for branches.
- branch_o, jump_o  out  1 each  conditional branch; JAL/JALR.
- slt_o  out  2  bit0=set-less-than, bit1=unsigned.
- illegal_o  out  1  unsupported opcode/funct.
- pc_o  out  32  PC of decoded instruction.

Behaviour:
- Reset (async): every output register 0, out_valid_o=0, in_ready_o=1.
- in_ready_o = !flush_i && (!out_valid_o || out_ready_i). Fully combinational; no bubble when both sides stream.
- Accept on in_valid_i && in_ready_o: decoded bundle registered; out_valid_o=1 next cycle. Latency 1 cycle.
- Bundle is held stable while out_valid_o && !out_ready_i.
- If out_ready_i && !accept, out_valid_o drops to 0 next cycle.
- flush_i: out_valid_o=0 next cycle, held bundle dropped; a same-cycle input is never accepted. flush_i has priority over out_ready_i and in_valid_i.
- Immediate formats:
  - OP-IMM/LOAD/JALR: I-type, sign-extended.
  - STORE: S-type.
  - BRANCH: B-type, bit0=0.
  - JAL: J-type.
  - LUI: instr[31:12] zero-extended, right-justified (the ALU shifts).
  - AUIPC: instr[31:12]<<12.
- Decode map:
  - OP/OP-IMM: ADD, SUB (funct7[5], OP only), AND, OR, XOR, SLL, SRL, SRA (funct7[5]).
  - SLT/SLTI and SLTU/SLTIU: alu_op=SUB, slt_o=01 or 11.
  - LUI: alu_op=LUI, op_b=imm.
  - AUIPC: alu_op=ADD, op_a=pc, op_b=imm.
  - LOAD/STORE: ADD, rs1+imm.
  - BRANCH: ADD, pc+imm, branch_o=1, reg_we=0.
  - JAL: ADD, pc+imm, jump_o=1, reg_we=1.
  - JALR: ADD, rs1+imm, jump_o=1, reg_we=1.
- Shift immediates with nonzero instr[31:25] (other than SRAI's 0100000): illegal.
- Illegal instruction: alu_op=OUT_ZERO, reg_we/mem/branch/jump=0, illegal_o=1, still presented as valid.
- rs2_o is driven from instr[24:20] for every format.
- reg_we_o=0 whenever rd=0.
- Reset asserted mid-stream: out_valid_o drops immediately (async); no partial bundle survives.

Decomposition:
- Shared package riscv_pkg holds:
  - alu_op_t enum with explicit 4-bit values.
  - Opcode constants (OPC_OP, OPC_OPIMM, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC).
  - funct3/funct7 constants.
- ALU migrates to the same package.
- One combinational sub-module, riscv_imm_gen (instr -> imm, format select), reused by fetch branch prediction later.

Test Plan:
- Reset then 0x00A00093 (addi x1,x0,10), out_ready=1 -> next cycle: out_valid=1, alu_op=0, imm=10, rd=1, reg_we=1, op_b_sel=1.
- 0x40208133 (sub x2,x1,x2) with out_ready=0 for 3 cycles -> alu_op=10 held stable, in_ready=0; completes on the first out_ready=1 cycle.
- 0x123450B7 (lui x1,0x12345) -> alu_op=9, imm=0x00012345. 0x00001097 (auipc) at pc=0x100 -> alu_op=0, op_a_sel=1, imm=0x1000.
- Back-to-back stream of 4 instructions with out_ready=1 -> 4 bundles in 4 consecutive cycles. flush_i in cycle 2 -> that bundle dropped, input not accepted, stream resumes cycle 3.
- Unsupported opcodes 0xFFFFFFFF and 0x0000007F -> illegal_o=1, alu_op=7, reg_we=0.
- Check slt (0x0020A1B3) -> alu_op=10, slt_o=01.
- Check sltiu -> slt_o=11.
- Check addi x0,x0,0 -> reg_we=0.
- Assert rst mid-stall -> out_valid_o=0 without a clock edge.
